fp_addsub_arbiter: RTL and testbench
====================================

FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 63: maximum WAIT cycles before abort; legal range 1..255.
REQ-002 SHALL have port CLK  in  1  system clock, rising edge.
REQ-003 SHALL have port RST_EX  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports REQ_X, REQ_Y, REQ_Z  in  1 each  level request for the shared floating-point add/subtract unit.
REQ-005 SHALL have ports ADD_SUBT_X, ADD_SUBT_Y, ADD_SUBT_Z  in  1 each  operation per requester: 0 add, 1 subtract.
REQ-006 SHALL have port ACK_ADD  in  1  shared-unit result-valid indication.
REQ-007 SHALL have port CLR_ERR  in  1  synchronous clear of TIMEOUT_ERR.
REQ-008 SHALL have port BEGIN_ADD  out  1  single-cycle start pulse to the shared unit.
REQ-009 SHALL have port ADD_SUBT  out  1  operation for the shared unit.
REQ-010 SHALL have port SEL  out  2  operand-mux select: 00 X, 01 Y, 10 Z, 11 none.
REQ-011 SHALL have ports EN_RES_X, EN_RES_Y, EN_RES_Z  out  1 each  one-cycle result-capture enable / completion ack.
REQ-012 SHALL have ports BUSY  out  1  (state not IDLE) and TIMEOUT_ERR  out  1  (sticky abort flag).

Function
REQ-013 SHALL implement states IDLE, GRANT, WAIT, DONE; all outputs decoded from registered state, grant and op registers only.
REQ-014 IDLE: with any REQ high, SHALL latch the winner into the grant register, latch its ADD_SUBT_n into the op register, and go to GRANT; otherwise stay in IDLE.
REQ-015 Winner SHALL be round-robin: search starts at the requester after the last granted one (X->Y->Z->X); after reset the last grant is Z, so X has first priority.
REQ-016 GRANT: BEGIN_ADD=1 for exactly one cycle, SEL=grant, ADD_SUBT=op; next state WAIT unconditionally; ACK_ADD SHALL be ignored in GRANT.
REQ-017 WAIT: SEL and ADD_SUBT held; ACK_ADD=1 -> DONE; 8-bit wait counter increments each WAIT cycle.
REQ-018 Counter reaching TIMEOUT_CYCLES with ACK_ADD=0 SHALL set TIMEOUT_ERR, go to IDLE without any EN_RES pulse, and update last-grant as if the grant had completed.
REQ-019 DONE: EN_RES_<grant>=1 for exactly one cycle, SEL still=grant, last-grant updated; next state IDLE.
REQ-020 Minimum latency: REQ sampled at edge 0 -> BEGIN_ADD in cycle 1 -> ACK_ADD sampled at edge 2 at earliest -> EN_RES in cycle 3.
REQ-021 Requester SHALL deassert REQ on the edge ending its EN_RES cycle; arbiter re-arbitrates in the IDLE cycle after DONE (one IDLE bubble between grants).
REQ-022 REQ dropped before being granted: no grant; REQ dropped after grant: ignored, transaction completes.
REQ-023 Changes to ADD_SUBT_n after grant SHALL NOT affect ADD_SUBT.
REQ-024 SEL=11, BEGIN_ADD=0, all EN_RES=0 whenever state is IDLE.
REQ-025 TIMEOUT_ERR SHALL remain set until CLR_ERR=1 or reset; if set and clear coincide, set wins.

Reset
REQ-026 RST_EX=1 SHALL force state IDLE, SEL=11, last-grant=Z, counter=0, op=0, TIMEOUT_ERR=0, and every other output 0, regardless of the current state.
REQ-027 Reset during WAIT SHALL abandon the transaction; no EN_RES pulse is generated after reset release.

Structure
REQ-028 Shared package SHALL hold state encoding, SEL codes (X, Y, Z, NONE) and default TIMEOUT_CYCLES.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick3 (inputs: 3-bit request, 2-bit last grant; output: 2-bit winner plus valid).

Verification
REQ-030 REQ_X=1, ADD_SUBT_X=1, ACK_ADD 2 cycles after BEGIN_ADD -> SEL=00, ADD_SUBT=1, single EN_RES_X pulse 4 cycles after request.
REQ-031 REQ_X/Y/Z all high at once from reset -> grant order X, Y, Z, each with exactly one BEGIN_ADD and one EN_RES pulse.
REQ-032 REQ_Y, then REQ_X and REQ_Z raised during Y's WAIT -> after Y completes, Z is served before X.
REQ-033 TIMEOUT_CYCLES=4, ACK_ADD held 0 -> TIMEOUT_ERR=1 after 4 WAIT cycles, no EN_RES, return to IDLE; CLR_ERR pulse -> TIMEOUT_ERR=0.
REQ-034 RST_EX asserted during WAIT -> outputs immediately at reset values; late ACK_ADD after release -> no EN_RES.
REQ-035 ADD_SUBT_Z toggled 0->1 during Z's WAIT -> ADD_SUBT remains 0 through DONE.

Source files
------------

// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared encodings for the FP add/sub arbiter: FSM states, operand-mux select codes, default timeout.
// Latency: n/a (types and constants only); backpressure: n/a.
package fp_addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_X    = 2'b00;
  localparam logic [1:0] SEL_Y    = 2'b01;
  localparam logic [1:0] SEL_Z    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int DEF_TIMEOUT_CYCLES = 63;

endpackage

// File: rtl/fp_addsub_arbiter_rr_pick3.sv
// Combinational 3-way round-robin pick; search begins at the requester after last_grant.
// Latency: 0 cycles; backpressure: none, vld simply follows any request.
module rr_pick3
  import fp_addsub_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] winner,
  output logic       vld
);

  always_comb begin
    winner = SEL_NONE;
    vld    = |req;
    case (last_grant)
      SEL_X: begin
        if (req[1])      winner = SEL_Y;
        else if (req[2]) winner = SEL_Z;
        else if (req[0]) winner = SEL_X;
      end
      SEL_Y: begin
        if (req[2])      winner = SEL_Z;
        else if (req[0]) winner = SEL_X;
        else if (req[1]) winner = SEL_Y;
      end
      default: begin
        if (req[0])      winner = SEL_X;
        else if (req[1]) winner = SEL_Y;
        else if (req[2]) winner = SEL_Z;
      end
    endcase
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one FP add/sub unit among X/Y/Z; REQ to EN_RES is 3 cycles minimum.
// Backpressure: a grant holds the unit until ACK_ADD or TIMEOUT_CYCLES WAIT cycles elapse.
module fp_addsub_arbiter
  import fp_addsub_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RST_EX,
  input  logic       REQ_X,
  input  logic       REQ_Y,
  input  logic       REQ_Z,
  input  logic       ADD_SUBT_X,
  input  logic       ADD_SUBT_Y,
  input  logic       ADD_SUBT_Z,
  input  logic       ACK_ADD,
  input  logic       CLR_ERR,
  output logic       BEGIN_ADD,
  output logic       ADD_SUBT,
  output logic [1:0] SEL,
  output logic       EN_RES_X,
  output logic       EN_RES_Y,
  output logic       EN_RES_Z,
  output logic       BUSY,
  output logic       TIMEOUT_ERR
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  state_t     state, state_nxt;
  logic [1:0] grant, last_grant;
  logic       op;
  logic [7:0] wait_cnt;
  logic       timeout_err;
  logic [1:0] pick;
  logic       pick_vld;
  logic       pick_op;
  logic       wait_expire;

  rr_pick3 u_rr_pick3 (
    .req        ({REQ_Z, REQ_Y, REQ_X}),
    .last_grant (last_grant),
    .winner     (pick),
    .vld        (pick_vld)
  );

  always_comb begin
    pick_op = ADD_SUBT_Z;
    case (pick)
      SEL_X:   pick_op = ADD_SUBT_X;
      SEL_Y:   pick_op = ADD_SUBT_Y;
      default: pick_op = ADD_SUBT_Z;
    endcase
  end

  // An ACK in the final allowed WAIT cycle still completes the transaction.
  assign wait_expire = (state == WAIT) && !ACK_ADD && ((wait_cnt + 8'd1) == TIMEOUT_CNT);

  always_ff @(posedge CLK or posedge RST_EX) begin
    if (RST_EX) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_vld) state_nxt = GRANT;
      GRANT: state_nxt = WAIT;
      WAIT: begin
        if (ACK_ADD)          state_nxt = DONE;
        else if (wait_expire) state_nxt = IDLE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_EX) begin
    if (RST_EX) begin
      grant       <= SEL_Z;
      last_grant  <= SEL_Z;
      op          <= 1'b0;
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant <= pick;
        op    <= pick_op;
      end
      if (state == GRANT)     wait_cnt <= 8'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      // An aborted grant still advances the round-robin pointer.
      if (state == DONE || wait_expire) last_grant <= grant;
      if (wait_expire)  timeout_err <= 1'b1;
      else if (CLR_ERR) timeout_err <= 1'b0;
    end
  end

  assign BUSY        = (state != IDLE);
  assign BEGIN_ADD   = (state == GRANT);
  assign SEL         = (state == IDLE) ? SEL_NONE : grant;
  assign ADD_SUBT    = op;
  assign EN_RES_X    = (state == DONE) && (grant == SEL_X);
  assign EN_RES_Y    = (state == DONE) && (grant == SEL_Y);
  assign EN_RES_Z    = (state == DONE) && (grant == SEL_Z);
  assign TIMEOUT_ERR = timeout_err;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Scoreboard bench for fp_addsub_arbiter: rounds of requests are modelled as ordered grant lists,
// a monitor pops and checks each grant, its hold phase and its completion or abort.
module tb_fp_addsub_arbiter;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RST_EX = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] ops = 3'b000;
  logic       ack = 1'b0;
  logic       clr = 1'b0;
  logic       begin_add, add_subt, en_res_x, en_res_y, en_res_z, busy, timeout_err;
  logic [1:0] sel;

  typedef struct {
    int id;
    bit op;
    bit ok;
    int lat;
  } exp_t;

  exp_t     exp_q[$];
  int       checks = 0;
  int       failures = 0;
  int       d_plan[3];
  bit [2:0] granted = 3'b000;
  int       outstanding = 0;
  int       ack_cnt = 0;
  int       last_m = 2;
  bit       exp_sticky = 0;

  fp_addsub_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_EX(RST_EX),
    .REQ_X(req[0]), .REQ_Y(req[1]), .REQ_Z(req[2]),
    .ADD_SUBT_X(ops[0]), .ADD_SUBT_Y(ops[1]), .ADD_SUBT_Z(ops[2]),
    .ACK_ADD(ack), .CLR_ERR(clr),
    .BEGIN_ADD(begin_add), .ADD_SUBT(add_subt), .SEL(sel),
    .EN_RES_X(en_res_x), .EN_RES_Y(en_res_y), .EN_RES_Z(en_res_z),
    .BUSY(busy), .TIMEOUT_ERR(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req_v, $time);
    end
  endtask

  // Monitor: every grant must match the head of the expected queue.
  initial begin : monitor
    exp_t       cur;
    bit         cur_vld = 0;
    bit         abort_now;
    int         age = 0;
    logic       prev_err = 1'b0;
    logic [2:0] en;
    forever begin
      @(negedge CLK);
      en = {en_res_z, en_res_y, en_res_x};
      abort_now = 0;
      if (RST_EX) begin
        cur_vld  = 0;
        prev_err = timeout_err;
        continue;
      end
      if (!busy) check("idle_outs", {26'd0, sel, begin_add, en}, {26'd0, 2'b11, 1'b0, 3'b000});
      if (begin_add) begin
        check("no_overlap", cur_vld, 0);
        check("grant_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          cur_vld = 1;
          age = 0;
          check("grant_sel", sel, cur.id);
          check("grant_op", add_subt, cur.op);
        end
      end else if (cur_vld) begin
        age++;
        if (en != 3'b000) begin
          check("done_ok", 1, cur.ok);
          check("done_en_res", en, 1 << cur.id);
          check("done_lat", age, cur.lat);
          check("done_sel", sel, cur.id);
          cur_vld = 0;
        end else if (!busy) begin
          abort_now = 1;
          check("abort_ok", cur.ok, 0);
          check("abort_lat", age, cur.lat);
          check("abort_err", timeout_err, 1);
          cur_vld = 0;
        end else begin
          check("hold_sel", sel, cur.id);
          check("hold_op", add_subt, cur.op);
        end
      end else begin
        check("stray_en_res", en, 0);
      end
      check("err_rise", timeout_err && !prev_err && !abort_now, 0);
      prev_err = timeout_err;
    end
  end

  // One cycle of environment behaviour: requesters and the shared-unit ACK responder.
  task automatic tick();
    logic [2:0] en;
    @(negedge CLK);
    en  = {en_res_z, en_res_y, en_res_x};
    ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) ack = 1'b1;
    end
    if (begin_add && sel != 2'b11) begin
      granted[sel] = 1'b1;
      if (d_plan[int'(sel)] == 0)       ack = 1'b1;
      else if (d_plan[int'(sel)] <= TO) ack_cnt = d_plan[int'(sel)];
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (granted[i] && (en[i] || !busy)) begin
          req[i] = 1'b0;
          granted[i] = 1'b0;
          outstanding--;
        end else if (granted[i]) begin
          ops[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end
      end
    end
  endtask

  // ACK delay in cycles after BEGIN_ADD; 0 = ACK only during GRANT, TO+1 = never.
  function automatic int rand_d();
    int r;
    r = $urandom_range(0, 7);
    return (r <= TO + 1) ? r : $urandom_range(1, TO);
  endfunction

  task automatic run_round(input int kind, input bit [2:0] set, input int lead,
                           input bit [2:0] op_in, input int d0, input int d1, input int d2,
                           input bit hold);
    int   d[3];
    int   order[$];
    int   l;
    int   budget;
    int   g;
    exp_t e;
    bit [2:0] members;
    d = '{d0, d1, d2};
    budget = 0;
    while (busy && budget < 100) begin tick(); budget++; end
    tick();
    check("err_sticky", timeout_err, exp_sticky);
    if (timeout_err) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("err_clear", timeout_err, 0);
    end
    clr = hold;
    members = set;
    l = last_m;
    if (kind == 1) begin
      members[lead] = 1'b1;
      order.push_back(lead);
      l = lead;
    end
    for (int k = 1; k <= 3; k++) begin
      int id;
      id = (l + k) % 3;
      if (set[id] && !(kind == 1 && id == lead)) order.push_back(id);
    end
    exp_sticky = 0;
    foreach (order[j]) begin
      e.id  = order[j];
      e.op  = op_in[order[j]];
      e.ok  = (d[order[j]] >= 1) && (d[order[j]] <= TO);
      e.lat = e.ok ? d[order[j]] + 1 : TO + 1;
      exp_q.push_back(e);
      if (!e.ok && !hold) exp_sticky = 1;
    end
    last_m = order[$];
    outstanding = 0;
    for (int i = 0; i < 3; i++) if (members[i]) begin
      d_plan[i] = d[i];
      ops[i] = op_in[i];
      outstanding++;
    end
    if (kind == 0) begin
      req = set;
      tick();
      check("req_to_begin", begin_add, 1);
      if (set != 3'b111 && $urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, 2);
        while (set[g]) g = (g + 1) % 3;
        req[g] = 1'b1;
        tick();
        req[g] = 1'b0;
      end
    end else begin
      req[lead] = 1'b1;
      tick();
      check("req_to_begin", begin_add, 1);
      tick();
      req = req | (set & ~(3'b001 << lead));
    end
    budget = 0;
    while (outstanding > 0 && budget < 200) begin tick(); budget++; end
    if (outstanding > 0) begin
      checks++;
      failures++;
      $display("FAIL round_timeout actual_outstanding=%0d required=0", outstanding);
      RST_EX = 1'b1;
      tick();
      exp_q.delete();
      req = 3'b000; granted = 3'b000; outstanding = 0; ack_cnt = 0;
      last_m = 2; exp_sticky = 0;
      RST_EX = 1'b0;
    end
    tick();
    clr = 1'b0;
  endtask

  task automatic reset_test();
    exp_t e;
    logic [2:0] seen;
    while (busy) tick();
    tick();
    if (timeout_err) begin clr = 1'b1; tick(); clr = 1'b0; end
    e.id = 0; e.op = 1; e.ok = 0; e.lat = TO + 1;
    exp_q.push_back(e);
    d_plan[0] = TO + 1;
    ops[0] = 1'b1;
    req[0] = 1'b1;
    outstanding = 1;
    tick();
    check("rst_req_to_begin", begin_add, 1);
    tick();
    tick();
    #2 RST_EX = 1'b1;
    #1 check("rst_outs", {24'd0, busy, sel, begin_add, en_res_z, en_res_y, en_res_x, add_subt, timeout_err},
                         {24'd0, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    req = 3'b000; granted = 3'b000; outstanding = 0;
    last_m = 2; exp_sticky = 0;
    tick();
    RST_EX = 1'b0;
    ack_cnt = 1;
    seen = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | {en_res_z, en_res_y, en_res_x} | {2'b00, busy};
    end
    check("late_ack_no_en_res", seen, 0);
  endtask

  initial begin : stim
    bit [2:0] s;
    int       kind, lead;
    repeat (3) @(negedge CLK);
    check("reset_outs", {24'd0, busy, sel, begin_add, en_res_z, en_res_y, en_res_x, add_subt, timeout_err},
                        {24'd0, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    RST_EX = 1'b0;
    run_round(0, 3'b111, 0, 3'b101, 1, 2, 3, 0);       // all at once from reset: X, Y, Z
    run_round(0, 3'b001, 0, 3'b001, 2, 1, 1, 0);       // X subtract, ACK 2 cycles after BEGIN
    run_round(1, 3'b101, 1, 3'b010, 1, 2, 1, 0);       // Y first, then Z before X
    run_round(0, 3'b001, 0, 3'b000, TO + 1, 1, 1, 0);  // X never acked: timeout
    run_round(0, 3'b100, 0, 3'b000, 1, 1, 3, 0);       // Z add, op toggled during WAIT
    run_round(0, 3'b011, 0, 3'b010, 0, 4, 1, 1);       // ACK only in GRANT, clear held: set wins
    reset_test();
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 1);
      lead = $urandom_range(0, 2);
      s = 3'($urandom_range(1, 7));
      if (kind == 1) s = s & ~(3'b001 << lead);
      run_round(kind, s, lead, 3'($urandom_range(0, 7)), rand_d(), rand_d(), rand_d(),
                $urandom_range(0, 3) == 0);
    end
    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
